// File: rtl/debug_access_bridge_pkg.sv
// Shared definitions for the debug access bridge: mode encodings,
// bridge FSM states and the default error read-back word.
package debug_pkg;

  typedef logic [2:0] dbg_mode_t;

  localparam dbg_mode_t DBG_NOP    = 3'b000;
  localparam dbg_mode_t DBG_RF_RD  = 3'b001;
  localparam dbg_mode_t DBG_MEM_RD = 3'b010;
  localparam dbg_mode_t DBG_RF_WR  = 3'b101;
  localparam dbg_mode_t DBG_MEM_WR = 3'b110;

  localparam logic [31:0] DBG_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RF_RD,
    ST_RF_CAP,
    ST_RF_WR,
    ST_MEM,
    ST_DONE,
    ST_HOLD
  } dbg_state_e;

endpackage

// File: rtl/debug_access_bridge_if.sv
// Controller-side request/response handshake of the debug access bridge.
// master = Avalon-side debug controller, slave = bridge.
interface debug_access_bridge_if;
  import debug_pkg::*;

  logic        tx_flag;
  dbg_mode_t   mode;
  logic [31:0] address_bridged;
  logic [31:0] data_bridged;
  logic        err_clr;
  logic        doneSending;
  logic [31:0] data_internal;
  logic        err;

  modport master (
    output tx_flag, mode, address_bridged, data_bridged, err_clr,
    input  doneSending, data_internal, err
  );

  modport slave (
    input  tx_flag, mode, address_bridged, data_bridged, err_clr,
    output doneSending, data_internal, err
  );

endinterface

// File: rtl/debug_access_bridge_timeout.sv
// dbg_timeout_counter: loadable down-counter bounding the wait for mem_ack.
// expire_o fires on the decrement that would take the count from 1 to 0,
// so a load of MAX followed by MAX-1 decrements gives MAX waiting cycles.
module dbg_timeout_counter #(
  parameter int unsigned MAX = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(MAX);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: reload on a new request, otherwise count down to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                 cnt_d = LOAD_VAL;
    else if (dec_i && cnt_q != '0) cnt_d = cnt_q - ONE;
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign expire_o = dec_i && (cnt_q == ONE);

endmodule

// File: rtl/debug_access_bridge.sv
// debug_access_bridge: target-side responder that executes debug read/write
// requests against the halted core's register-file or data-memory debug port.
// Optional macro DBG_BRIDGE_ALIGN_CHECK_EN rejects misaligned MEM requests.
module debug_access_bridge
  import debug_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned RF_ADDR_W      = 5,
  parameter logic [31:0] ERR_DATA       = DBG_ERR_DATA
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  debug_access_bridge_if.slave dbg,
  output logic                 rf_re,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_addr,
  output logic [31:0]          rf_wdata,
  input  logic [31:0]          rf_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ack
);

  dbg_state_e           state_q, state_d;
  logic                 done_q, done_d;
  logic [31:0]          di_q, di_d;
  logic                 err_q, err_d;
  logic                 rf_re_q, rf_re_d;
  logic                 rf_we_q, rf_we_d;
  logic [RF_ADDR_W-1:0] rf_addr_q, rf_addr_d;
  logic [31:0]          rf_wdata_q, rf_wdata_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [31:0]          mem_addr_q, mem_addr_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;
  logic                 rd_q, rd_d;     // MEM request is a read
  logic                 bad_q, bad_d;   // request rejected, no access issued
  logic                 zero_q, zero_d; // RF index 0 (hardwired zero register)

  logic                 set_err;
  logic                 tmo_load, tmo_dec, tmo_exp;
  logic                 rf_oob, rf_zero, mem_misal;
  logic [RF_ADDR_W-1:0] rf_idx;

  assign rf_idx  = dbg.address_bridged[RF_ADDR_W-1:0];
  assign rf_oob  = |dbg.address_bridged[31:RF_ADDR_W];
  assign rf_zero = (rf_idx == '0);
`ifdef DBG_BRIDGE_ALIGN_CHECK_EN
  assign mem_misal = |dbg.address_bridged[1:0];
`else
  assign mem_misal = 1'b0;
`endif

  dbg_timeout_counter #(.MAX(TIMEOUT_CYCLES)) u_tmo (
    .clk      (CLK),
    .rst_n    (RST_n),
    .load_i   (tmo_load),
    .dec_i    (tmo_dec),
    .expire_o (tmo_exp)
  );

  // Request FSM: accept, issue the access, complete, then wait for tx_flag low.
  always_comb begin
    state_d     = state_q;
    done_d      = 1'b0;
    di_d        = di_q;
    rf_re_d     = 1'b0;
    rf_we_d     = 1'b0;
    rf_addr_d   = rf_addr_q;
    rf_wdata_d  = rf_wdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rd_d        = rd_q;
    bad_d       = bad_q;
    zero_d      = zero_q;
    set_err     = 1'b0;
    tmo_load    = 1'b0;
    tmo_dec     = 1'b0;

    case (state_q)
      ST_IDLE: if (dbg.tx_flag) begin
        case (dbg.mode)
          DBG_RF_RD: begin
            state_d   = ST_RF_RD;
            rf_addr_d = rf_idx;
            bad_d     = rf_oob;
            zero_d    = rf_zero;
            rf_re_d   = !rf_oob && !rf_zero;
          end
          DBG_RF_WR: begin
            state_d    = ST_RF_WR;
            rf_addr_d  = rf_idx;
            rf_wdata_d = dbg.data_bridged;
            bad_d      = rf_oob;
            zero_d     = rf_zero;
            rf_we_d    = !rf_oob && !rf_zero;
          end
          DBG_MEM_RD, DBG_MEM_WR: begin
            state_d     = ST_MEM;
            rd_d        = (dbg.mode == DBG_MEM_RD);
            bad_d       = mem_misal;
            mem_addr_d  = dbg.address_bridged;
            mem_wdata_d = dbg.data_bridged;
            mem_req_d   = !mem_misal;
            mem_we_d    = !mem_misal && (dbg.mode == DBG_MEM_WR);
            tmo_load    = 1'b1;
          end
          default: begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        endcase
      end
      ST_RF_RD: state_d = ST_RF_CAP;
      ST_RF_CAP: begin
        if (bad_q)       di_d = ERR_DATA;
        else if (zero_q) di_d = '0;
        else             di_d = rf_rdata;
        set_err = bad_q;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_RF_WR: begin
        set_err = bad_q;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      ST_MEM: begin
        if (bad_q) begin
          set_err = 1'b1;
          if (rd_q) di_d = ERR_DATA;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (mem_ack) begin
          if (rd_q) di_d = mem_rdata;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end else begin
          tmo_dec = 1'b1;
          if (tmo_exp) begin
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
            set_err   = 1'b1;
            if (rd_q) di_d = ERR_DATA;
            done_d    = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_HOLD;
      ST_HOLD: if (!dbg.tx_flag) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky error: a new error outranks a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (dbg.err_clr) err_d = 1'b0;
    if (set_err)     err_d = 1'b1;
  end

  // State and registered outputs; reset drops every strobe asynchronously.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= ST_IDLE;
      done_q      <= 1'b0;
      di_q        <= '0;
      err_q       <= 1'b0;
      rf_re_q     <= 1'b0;
      rf_we_q     <= 1'b0;
      rf_addr_q   <= '0;
      rf_wdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_q        <= 1'b0;
      bad_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= done_d;
      di_q        <= di_d;
      err_q       <= err_d;
      rf_re_q     <= rf_re_d;
      rf_we_q     <= rf_we_d;
      rf_addr_q   <= rf_addr_d;
      rf_wdata_q  <= rf_wdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_q        <= rd_d;
      bad_q       <= bad_d;
      zero_q      <= zero_d;
    end
  end

  assign dbg.doneSending   = done_q;
  assign dbg.data_internal = di_q;
  assign dbg.err           = err_q;
  assign rf_re             = rf_re_q;
  assign rf_we             = rf_we_q;
  assign rf_addr           = rf_addr_q;
  assign rf_wdata          = rf_wdata_q;
  assign mem_req           = mem_req_q;
  assign mem_we            = mem_we_q;
  assign mem_addr          = mem_addr_q;
  assign mem_wdata         = mem_wdata_q;

endmodule

// File: tb/tb_debug_access_bridge.sv
// Directed bench for debug_access_bridge: RF/no-op vectors from a table,
// hand-written sequences for memory handshakes, timeout and reset.
module tb_debug_access_bridge;
  import debug_pkg::*;

  logic        CLK, RST_n;
  logic        rf_re, rf_we, mem_req, mem_we, mem_ack;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata, rf_rdata, mem_addr, mem_wdata, mem_rdata;

  debug_access_bridge_if dbg();

  debug_access_bridge dut (
    .CLK(CLK), .RST_n(RST_n), .dbg(dbg),
    .rf_re(rf_re), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int failures = 0;

  // Results of the last transaction.
  int          r_we, r_re, r_req, r_done_cnt, r_done_at;
  logic        r_err_at_done, r_mem_we;
  logic [31:0] r_rf_addr, r_rf_wdata, r_mem_addr, r_mem_wdata;

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          we;
    int          re;
    int          done_at;
    logic [31:0] di;
    logic        err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clr_err();
    @(negedge CLK);
    dbg.err_clr = 1'b1;
    @(negedge CLK);
    dbg.err_clr = 1'b0;
  endtask

  // One request held for max_cyc cycles; request inputs are scrambled after
  // the accept edge to confirm they are latched. Optional memory ack after
  // ack_after cycles of mem_req, optional tx_flag drop at cycle drop_at.
  task automatic txn(input logic [2:0] md, input logic [31:0] ad, input logic [31:0] wd,
                     input int ack_after, input logic [31:0] rd, input int drop_at,
                     input int max_cyc);
    bit acked;
    acked = 1'b0;
    r_we = 0; r_re = 0; r_req = 0; r_done_cnt = 0; r_done_at = 0;
    r_err_at_done = 1'b0; r_mem_we = 1'b0;
    r_rf_addr = '0; r_rf_wdata = '0; r_mem_addr = '0; r_mem_wdata = '0;
    @(negedge CLK);
    dbg.mode = md; dbg.address_bridged = ad; dbg.data_bridged = wd; dbg.tx_flag = 1'b1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(posedge CLK); #1;
      if (k == 1) begin
        dbg.address_bridged = '1; dbg.data_bridged = '0; dbg.mode = 3'b111;
      end
      if (mem_ack) mem_ack = 1'b0;
      if (rf_we) begin r_we++; r_rf_addr = 32'(rf_addr); r_rf_wdata = rf_wdata; end
      if (rf_re) begin r_re++; r_rf_addr = 32'(rf_addr); end
      if (mem_req) begin
        r_req++; r_mem_addr = mem_addr; r_mem_we = mem_we; r_mem_wdata = mem_wdata;
      end
      if (dbg.doneSending) begin
        r_done_cnt++;
        if (r_done_at == 0) begin r_done_at = k; r_err_at_done = dbg.err; end
      end
      if (k == drop_at) dbg.tx_flag = 1'b0;
      if (ack_after > 0 && !acked && mem_req && r_req == ack_after) begin
        mem_ack = 1'b1; mem_rdata = rd; acked = 1'b1;
      end
    end
    dbg.tx_flag = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic apply_vec(input int i);
    clr_err();
    rf_rdata = vecs[i].rdata;
    txn(vecs[i].mode, vecs[i].addr, vecs[i].wdata, 0, 32'h0, 0, 8);
    chk($sformatf("v%0d_rf_we", i),    r_we,              vecs[i].we);
    chk($sformatf("v%0d_rf_re", i),    r_re,              vecs[i].re);
    chk($sformatf("v%0d_mem_req", i),  r_req,             0);
    chk($sformatf("v%0d_done_cnt", i), r_done_cnt,        1);
    chk($sformatf("v%0d_done_at", i),  r_done_at,         vecs[i].done_at);
    chk($sformatf("v%0d_data", i),     dbg.data_internal, vecs[i].di);
    chk($sformatf("v%0d_err", i),      32'(r_err_at_done), 32'(vecs[i].err));
    if (vecs[i].we != 0 || vecs[i].re != 0)
      chk($sformatf("v%0d_rf_addr", i), r_rf_addr, vecs[i].addr);
    if (vecs[i].we != 0)
      chk($sformatf("v%0d_rf_wdata", i), r_rf_wdata, vecs[i].wdata);
  endtask

  initial begin
    //            mode        addr          wdata         rdata        we re done di            err
    vecs[0] = '{DBG_RF_WR,  32'h0000_0003, 32'h1234_5678, 32'h0,        1, 0, 2, 32'h0,         1'b0};
    vecs[1] = '{DBG_RF_RD,  32'h0000_0003, 32'h0,         32'hCAFE_0001, 0, 1, 3, 32'hCAFE_0001, 1'b0};
    vecs[2] = '{DBG_NOP,    32'h0000_0004, 32'h0,         32'h0,        0, 0, 1, 32'hCAFE_0001, 1'b0};
    vecs[3] = '{DBG_RF_RD,  32'h0000_0000, 32'h0,         32'h1111_1111, 0, 0, 3, 32'h0,         1'b0};
    vecs[4] = '{DBG_RF_WR,  32'h0000_0000, 32'h5555_AAAA, 32'h0,        0, 0, 2, 32'h0,         1'b0};
    vecs[5] = '{DBG_RF_WR,  32'h0000_0020, 32'h7777_7777, 32'h0,        0, 0, 2, 32'h0,         1'b1};
    vecs[6] = '{DBG_RF_RD,  32'h0000_0020, 32'h0,         32'h2222_2222, 0, 0, 3, 32'hDEAD_BEEF, 1'b1};
    vecs[7] = '{3'b011,     32'h0000_0005, 32'h0,         32'h0,        0, 0, 1, 32'hDEAD_BEEF, 1'b0};
    vecs[8] = '{DBG_RF_RD,  32'h0000_001F, 32'h0,         32'h8765_4321, 0, 1, 3, 32'h8765_4321, 1'b0};

    RST_n = 1'b0;
    dbg.tx_flag = 1'b0; dbg.mode = '0; dbg.address_bridged = '0; dbg.data_bridged = '0;
    dbg.err_clr = 1'b0;
    rf_rdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    #12;
    chk("rst_strobes", {26'h0, rf_re, rf_we, mem_req, mem_we, dbg.doneSending, dbg.err}, 32'h0);
    chk("rst_data", dbg.data_internal, 32'h0);
    chk("rst_buses", rf_wdata | mem_addr | mem_wdata | 32'(rf_addr), 32'h0);
    @(negedge CLK);
    RST_n = 1'b1;

    for (int i = 0; i < 9; i++) apply_vec(i);

    // Memory read, ack during the fifth cycle of mem_req.
    clr_err();
    txn(DBG_MEM_RD, 32'h0000_0100, 32'h0, 5, 32'hA5A5_A5A5, 0, 12);
    chk("mrd_req_cycles", r_req, 5);
    chk("mrd_addr", r_mem_addr, 32'h0000_0100);
    chk("mrd_we", 32'(r_mem_we), 32'h0);
    chk("mrd_done_at", r_done_at, 6);
    chk("mrd_done_cnt", r_done_cnt, 1);
    chk("mrd_data", dbg.data_internal, 32'hA5A5_A5A5);
    chk("mrd_err", 32'(r_err_at_done), 32'h0);

    // Memory write with immediate ack: data_internal untouched.
    txn(DBG_MEM_WR, 32'h0000_0200, 32'hDDCC_BBAA, 1, 32'h0BAD_0BAD, 0, 6);
    chk("mwr_req_cycles", r_req, 1);
    chk("mwr_we", 32'(r_mem_we), 32'h1);
    chk("mwr_wdata", r_mem_wdata, 32'hDDCC_BBAA);
    chk("mwr_addr", r_mem_addr, 32'h0000_0200);
    chk("mwr_done_at", r_done_at, 2);
    chk("mwr_data", dbg.data_internal, 32'hA5A5_A5A5);

    // Misaligned memory read.
`ifdef DBG_BRIDGE_ALIGN_CHECK_EN
    txn(DBG_MEM_RD, 32'h0000_0102, 32'h0, 0, 32'h0, 0, 6);
    chk("mis_req", r_req, 0);
    chk("mis_done_at", r_done_at, 2);
    chk("mis_err", 32'(r_err_at_done), 32'h1);
    chk("mis_data", dbg.data_internal, 32'hDEAD_BEEF);
    clr_err();
`else
    txn(DBG_MEM_RD, 32'h0000_0102, 32'h0, 1, 32'h0000_0102, 0, 6);
    chk("mis_req", r_req, 1);
    chk("mis_addr", r_mem_addr, 32'h0000_0102);
    chk("mis_err", 32'(r_err_at_done), 32'h0);
    chk("mis_data", dbg.data_internal, 32'h0000_0102);
`endif

    // tx_flag dropped right after accept: access still completes once.
    txn(DBG_MEM_RD, 32'h0000_0500, 32'h0, 3, 32'h5555_0005, 1, 10);
    chk("drop_req_cycles", r_req, 3);
    chk("drop_done_at", r_done_at, 4);
    chk("drop_done_cnt", r_done_cnt, 1);
    chk("drop_data", dbg.data_internal, 32'h5555_0005);

    // Memory timeout.
    txn(DBG_MEM_RD, 32'h0000_0300, 32'h0, 0, 32'h0, 0, 270);
    chk("tmo_req_cycles", r_req, 256);
    chk("tmo_done_at", r_done_at, 257);
    chk("tmo_done_cnt", r_done_cnt, 1);
    chk("tmo_err", 32'(r_err_at_done), 32'h1);
    chk("tmo_data", dbg.data_internal, 32'hDEAD_BEEF);
    chk("tmo_err_held", 32'(dbg.err), 32'h1);
    clr_err();
    chk("tmo_err_clr", 32'(dbg.err), 32'h0);

    // A new error on the same edge as err_clr sets the flag.
    @(negedge CLK);
    dbg.err_clr = 1'b1;
    txn(DBG_RF_WR, 32'h0000_0020, 32'h0, 0, 32'h0, 0, 6);
    dbg.err_clr = 1'b0;
    chk("errwin_err", 32'(r_err_at_done), 32'h1);
    chk("errwin_we", r_we, 0);

    // Reset while a memory access is pending.
    @(negedge CLK);
    dbg.mode = DBG_MEM_RD; dbg.address_bridged = 32'h0000_0400; dbg.tx_flag = 1'b1;
    repeat (3) @(posedge CLK);
    #2;
    chk("rmid_req_before", 32'(mem_req), 32'h1);
    RST_n = 1'b0;
    #1;
    chk("rmid_req", 32'(mem_req), 32'h0);
    chk("rmid_strobes", {26'h0, rf_re, rf_we, mem_req, mem_we, dbg.doneSending, dbg.err}, 32'h0);
    chk("rmid_data", dbg.data_internal | mem_addr, 32'h0);
    dbg.tx_flag = 1'b0;
    @(negedge CLK);
    RST_n = 1'b1;
    apply_vec(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debug_access_bridge.md
Name: debug_access_bridge

Overview:
- Target-side responder for the debug access handshake: tx_flag, mode, address_bridged and data_bridged in; doneSending and data_internal out.
- Executes each requested read or write against the core's register-file debug port or data-memory debug port.
- Sits between the Avalon-side debug controller and the halted RISC-V core.
- Returns read data and a one-cycle completion pulse, with timeout and error reporting.

Parameters:
- TIMEOUT_CYCLES, 256: max cycles waiting for mem_ack before aborting.
- RF_ADDR_W, 5: register-file index width.
- ERR_DATA, 32'hDEAD_BEEF: value returned on a failed read.

Ports:
- CLK  in  1  system clock
- RST_n  in  1  asynchronous active-low reset
- tx_flag  in  1  request valid, level; held until doneSending seen
- mode  in  3  001 RF read, 010 MEM read, 101 RF write, 110 MEM write; others no access
- address_bridged  in  32  RF index or byte address
- data_bridged  in  32  write data
- doneSending  out  1  one-cycle completion pulse
- data_internal  out  32  last read result
- err  out  1  sticky error flag
- err_clr  in  1  clears err
- rf_re  out  1  RF read strobe
- rf_we  out  1  RF write strobe
- rf_addr  out  RF_ADDR_W  RF index
- rf_wdata  out  32  RF write data
- rf_rdata  in  32  RF read data, valid one cycle after rf_re
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  memory write qualifier
- mem_addr  out  32  memory byte address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion

Behaviour:
- Clock, reset and outputs:
  - One clock, CLK.
  - RST_n is asynchronous, active-low.
  - All outputs are registered.
  - Reset values: every output 0, data_internal 0, state IDLE, timeout counter 0.
- States: IDLE, RF_RD, RF_CAP, RF_WR, MEM, DONE, HOLD.
- IDLE:
  - tx_flag sampled high at edge E accepts the request.
  - mode, address and data are latched at E; later changes are ignored until HOLD exits.
  - mode 001: go to RF_RD.
  - mode 101: go to RF_WR.
  - mode 010 or 110: go to MEM.
  - Any other mode: go to DONE directly, with no access.
- RF_RD:
  - rf_re=1 and rf_addr driven for the cycle after E.
  - RF_CAP captures rf_rdata into data_internal at E+2.
  - doneSending is high for the cycle after E+2.
- RF_WR:
  - rf_we=1 for the cycle after E.
  - doneSending is high for the cycle after E+1.
- Register-file boundary cases:
  - Index 0 write: rf_we suppressed, completion still given.
  - Index 0 read: data_internal = 0.
  - address_bridged[31:RF_ADDR_W] nonzero: no access, err=1, data_internal=ERR_DATA for reads, completion given.
- MEM:
  - mem_req, mem_we, mem_addr and mem_wdata are asserted from the cycle after E until the edge sampling mem_ack=1.
  - A read captures mem_rdata at that edge.
  - mem_req deasserts the next cycle.
  - doneSending follows one cycle after the ack edge.
  - The counter increments each cycle without ack. When it reaches TIMEOUT_CYCLES: mem_req drops, err=1, read returns ERR_DATA, completion given.
- DONE: pulses doneSending for 1 cycle, then goes to HOLD.
- HOLD:
  - Waits for tx_flag low, which prevents re-execution of a still-asserted request.
  - Returns to IDLE on the cycle tx_flag is sampled low.
- data_internal is unchanged by writes and no-op modes.
- tx_flag dropped mid-access: the access still completes (no abort of the memory handshake), doneSending still pulses, then the block returns to IDLE.
- Reset mid-access: mem_req, rf_we and rf_re drop asynchronously; the pending access is lost.
- err_clr and a new error on the same cycle: the error wins.

Optional Feature:
- Macro DBG_BRIDGE_ALIGN_CHECK_EN.
- Defined: a MEM request with address_bridged[1:0] != 0 issues no mem_req, sets err, returns ERR_DATA on reads, and completes in 2 cycles.
- Undefined: the address is passed unchanged; alignment is left to memory.

Decomposition:
- Shared package debug_pkg holds:
  - mode encodings as constants (DBG_NOP=000, DBG_RF_RD=001, DBG_MEM_RD=010, DBG_RF_WR=101, DBG_MEM_WR=110);
  - the bridge state enum;
  - ERR_DATA default.
- One sub-module is natural: dbg_timeout_counter, a loadable down-counter with an expire flag.

Test Plan:
- RF write: mode=101, addr=3, data=32'h1234_5678, tx_flag=1 → rf_we one cycle with rf_addr=3; doneSending exactly one pulse at E+1; no repeat while tx_flag held.
- RF read: mode=001, addr=3, rf_rdata=32'hCAFE_0001 → data_internal=32'hCAFE_0001 at E+2; doneSending one cycle. Index 0 read → 0.
- MEM read, ack after 5 cycles: mem_req high exactly 5 cycles, addr 32'h0000_0100, mem_rdata=32'hA5A5_A5A5 → data_internal matches; done one cycle after ack; err=0.
- MEM timeout: mem_ack never asserted → mem_req drops after 256 cycles, err=1, data_internal=32'hDEAD_BEEF, doneSending pulse; err_clr → err=0.
- RF address out of range: addr=32'h20 with mode 101 → no rf_we, err=1, doneSending pulse. With DBG_BRIDGE_ALIGN_CHECK_EN: mode 010, addr=32'h0000_0102 → no mem_req, err=1.
- Reset mid-MEM access: RST_n low during MEM → mem_req=0 immediately, all outputs 0; after release a new request is accepted normally.
